ahb_slave_decoder: RTL and testbench
====================================

# ahb_slave_decoder

Parametrised AHB-Lite address decoder with an integrated slave-response multiplexer and a built-in default slave. It decodes the address phase into one-hot slave selects and tracks which slave owns the data phase. It routes that slave's read data, ready and response back to the master, and answers unmapped accesses with a two-cycle ERROR. It sits between the single AHB master port and `SLAVE_DEVICES` AHB slaves. It replaces the fixed four-slave decoder, adding generic slave count and region size, HTRANS awareness, and the default slave.

## Interface
- `AHB_BASE_ADDR`, 32'h20304000: base of the decoded window. Only bits `[AHB_ADDR_WIDTH-1:AHB_SPACE_WIDTH]` are compared.
- `AHB_SPACE_WIDTH`, 16: log2 of the total window size.
- `AHB_ADDR_WIDTH`, 32: address width.
- `AHB_DATA_WIDTH`, 32: read data width.
- `SLAVE_DEVICES`, 4: number of slaves, 1..16.
- `SLAVE_SPACE_WIDTH`, 10: log2 of each slave region. Constraint: `SLAVE_SPACE_WIDTH + $clog2(SLAVE_DEVICES) <= AHB_SPACE_WIDTH`.
- `ahb_clk_in`  in  1  AHB clock. This is the block's single clock.
- `ahb_rstn_in`  in  1  Reset, asynchronous, active-low.
- `ahb_addr_in`  in  AHB_ADDR_WIDTH  HADDR (address phase).
- `ahb_trans_in`  in  2  HTRANS. IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `ahb_ready_in`  in  1  Global HREADY, fed back from the interconnect.
- `slave_sel_out`  out  SLAVE_DEVICES  One-hot HSELx.
- `slave_rdata_in`  in  SLAVE_DEVICES*AHB_DATA_WIDTH  Concatenated HRDATA. Slave k occupies bits `[k*DW +: DW]`.
- `slave_readyout_in`  in  SLAVE_DEVICES  HREADYOUT per slave.
- `slave_resp_in`  in  SLAVE_DEVICES  HRESP per slave (1=ERROR).
- `ahb_rdata_out`  out  AHB_DATA_WIDTH  Muxed HRDATA.
- `ahb_ready_out`  out  1  Muxed HREADY.
- `ahb_resp_out`  out  1  Muxed HRESP.
- `err_cnt_out`  out  8  Saturating count of ERROR responses issued by the default slave.

## Operation
- **Address decode (combinational).**
  - `hit_base` = (`ahb_addr_in[AW-1:AHB_SPACE_WIDTH]` == `AHB_BASE_ADDR[AW-1:AHB_SPACE_WIDTH]`).
  - `idx` = `ahb_addr_in[AHB_SPACE_WIDTH-1:SLAVE_SPACE_WIDTH]`.
  - Slave k is selected iff `hit_base` and `idx` == k with k < `SLAVE_DEVICES`. This sets `slave_sel_out[k]`=1.
  - Select does not depend on HTRANS; slaves qualify selection with HTRANS themselves.
  - Every other address (outside the base window, or `idx` >= `SLAVE_DEVICES`) drives `slave_sel_out`=0 and selects the default slave.
- **Data-phase owner register.** Holds fields `dp_idx` and `dp_default`.
  - Loaded from the current decode on every rising edge where `ahb_ready_in`=1.
  - Held while `ahb_ready_in`=0.
- **Response mux, slave owner.** When `dp_default`=0: `ahb_rdata_out`=`slave_rdata_in[dp_idx]`, `ahb_ready_out`=`slave_readyout_in[dp_idx]`, `ahb_resp_out`=`slave_resp_in[dp_idx]`.
- **Response mux, default owner.** When `dp_default`=1: `ahb_rdata_out`=0, and ready/resp come from the default-slave FSM.
- **Default-slave FSM states.**
  - DS_OKAY: ready=1, resp=0.
  - DS_ERR1: ready=0, resp=1.
  - DS_ERR2: ready=1, resp=1.
- **Default-slave FSM transitions.**
  - DS_OKAY→DS_ERR1 when `ahb_ready_in`=1, the decode selects the default slave, and `ahb_trans_in[1]`=1 (NONSEQ/SEQ).
  - DS_ERR1→DS_ERR2 unconditionally.
  - DS_ERR2→DS_ERR1 if a new default-slave NONSEQ/SEQ transfer is accepted in that cycle; otherwise DS_ERR2→DS_OKAY.
  - IDLE or BUSY to an unmapped address gives a zero-wait OKAY (stays in DS_OKAY).
- **`err_cnt_out`.** Increments by 1 on each entry to DS_ERR1 and saturates at 8'hFF.

## Timing
- **Reset values.** `dp_default`=1, `dp_idx`=0, FSM=DS_OKAY, `err_cnt_out`=0. Outputs: `ahb_ready_out`=1, `ahb_resp_out`=0, `ahb_rdata_out`=0. `slave_sel_out` follows the address combinationally.
- **Latency.** `slave_sel_out` has zero-cycle latency from the address. The response mux switches to the new owner one edge after the address is accepted with `ahb_ready_in`=1.
- **Wait states.** A slave wait state (`slave_readyout_in[k]`=0) freezes the owner register and the FSM. The next address is held until ready returns.
- **Default ERROR timing.** An unmapped NONSEQ accepted at edge N gives ready=0/resp=1 in cycle N+1 and ready=1/resp=1 in cycle N+2. The next transfer's address is accepted at the end of cycle N+2.
- **Back-to-back unmapped transfers.** ERR1, ERR2, ERR1, ERR2, … with no OKAY cycle between them.
- **Owner change.** Changing from a slave to the default slave (or back) on consecutive transfers causes no bubble.
- **Reset mid-operation.** Reset asserted during DS_ERR1 or a slave wait state returns immediately to the reset values.

## Test plan
- **Reset.** Assert reset, release, then drive IDLE at 0x0 → `ahb_ready_out`=1, `ahb_resp_out`=0, `err_cnt_out`=0, `slave_sel_out`=0.
- **Mapped reads.** NONSEQ to 0x20300000, 0x20300400, 0x20300800, 0x20300C00 back-to-back. Slave k returns 0xA0+k with zero wait → `slave_sel_out`=1,2,4,8 in successive cycles. `ahb_rdata_out`=0xA0..0xA3 one cycle later.
- **Wait state.** NONSEQ to 0x20300400 while slave1 holds readyout=0 for 3 cycles, with NONSEQ to 0x20300800 pending → owner stays 1 for 3 cycles, then switches to 2.
- **Unmapped accesses.** NONSEQ to 0x20301000 (idx 4) followed by NONSEQ to 0x40000000 → ready/resp sequence 0/1, 1/1, 0/1, 1/1. Afterwards `err_cnt_out`=2 and `ahb_rdata_out`=0.
- **IDLE to unmapped.** IDLE to 0x40000000 → ready=1, resp=0, `err_cnt_out` unchanged.
- **Saturation and reset.** 260 unmapped NONSEQ transfers → `err_cnt_out`=0xFF. Asserting reset during DS_ERR1 → ready=1, resp=0, count=0 immediately.

Source files
------------

// File: rtl/ahb_slave_decoder.sv
// AHB-Lite address decoder with data-phase response mux and a default slave that answers unmapped NONSEQ/SEQ with a two-cycle ERROR.
// Select is combinational from the address; the response mux follows the owner latched on each accepted address phase.
module ahb_slave_decoder #(
  parameter logic [31:0] AHB_BASE_ADDR     = 32'h20304000,
  parameter int          AHB_SPACE_WIDTH   = 16,
  parameter int          AHB_ADDR_WIDTH    = 32,
  parameter int          AHB_DATA_WIDTH    = 32,
  parameter int          SLAVE_DEVICES     = 4,
  parameter int          SLAVE_SPACE_WIDTH = 10
) (
  input  logic                                    ahb_clk_in,
  input  logic                                    ahb_rstn_in,
  input  logic [AHB_ADDR_WIDTH-1:0]               ahb_addr_in,
  input  logic [1:0]                              ahb_trans_in,
  input  logic                                    ahb_ready_in,
  output logic [SLAVE_DEVICES-1:0]                slave_sel_out,
  input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_rdata_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_readyout_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_resp_in,
  output logic [AHB_DATA_WIDTH-1:0]               ahb_rdata_out,
  output logic                                    ahb_ready_out,
  output logic                                    ahb_resp_out,
  output logic [7:0]                              err_cnt_out
);

  localparam int IW = AHB_SPACE_WIDTH - SLAVE_SPACE_WIDTH;
  localparam int PW = (SLAVE_DEVICES > 1) ? $clog2(SLAVE_DEVICES) : 1;
  localparam int DW = AHB_DATA_WIDTH;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  logic           hit_base;
  logic [IW-1:0]  dec_idx;
  logic           dec_default;
  logic           dflt_req;

  logic [PW-1:0]  dp_idx_q, dp_idx_d;
  logic           dp_default_q, dp_default_d;
  ds_state_e      state_q, state_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic           ds_ready;
  logic           ds_resp;

  localparam logic [AHB_ADDR_WIDTH-1:0] BASE = AHB_ADDR_WIDTH'(AHB_BASE_ADDR);

  assign hit_base    = (ahb_addr_in[AHB_ADDR_WIDTH-1:AHB_SPACE_WIDTH] ==
                        BASE[AHB_ADDR_WIDTH-1:AHB_SPACE_WIDTH]);
  assign dec_idx     = ahb_addr_in[AHB_SPACE_WIDTH-1:SLAVE_SPACE_WIDTH];
  assign dec_default = !hit_base || (32'(dec_idx) >= 32'(SLAVE_DEVICES));
  assign dflt_req    = ahb_ready_in && dec_default && ahb_trans_in[1];

  always_comb begin
    slave_sel_out = '0;
    for (int k = 0; k < SLAVE_DEVICES; k++) begin
      if (!dec_default && (32'(dec_idx) == 32'(k))) slave_sel_out[k] = 1'b1;
    end
  end

  always_comb begin
    dp_idx_d     = dp_idx_q;
    dp_default_d = dp_default_q;
    if (ahb_ready_in) begin
      dp_idx_d     = dec_default ? '0 : PW'(dec_idx);
      dp_default_d = dec_default;
    end
  end

  // Default-slave FSM; only DS_ERR1 holds the bus, which also freezes the owner.
  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    ds_ready  = 1'b1;
    ds_resp   = 1'b0;
    case (state_q)
      DS_OKAY: begin
        if (dflt_req) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ds_ready = 1'b0;
        ds_resp  = 1'b1;
        state_d  = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp = 1'b1;
        state_d = dflt_req ? DS_ERR1 : DS_OKAY;
      end
      default: state_d = DS_OKAY;
    endcase
    if ((state_d == DS_ERR1) && (state_q != DS_ERR1) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      dp_idx_q     <= '0;
      dp_default_q <= 1'b1;
      state_q      <= DS_OKAY;
      err_cnt_q    <= 8'd0;
    end else begin
      dp_idx_q     <= dp_idx_d;
      dp_default_q <= dp_default_d;
      state_q      <= state_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    ahb_rdata_out = '0;
    ahb_ready_out = ds_ready;
    ahb_resp_out  = ds_resp;
    if (!dp_default_q) begin
      for (int k = 0; k < SLAVE_DEVICES; k++) begin
        if (32'(dp_idx_q) == 32'(k)) begin
          ahb_rdata_out = slave_rdata_in[k*DW +: DW];
          ahb_ready_out = slave_readyout_in[k];
          ahb_resp_out  = slave_resp_in[k];
        end
      end
    end
  end

  assign err_cnt_out = err_cnt_q;

endmodule

// File: tb/tb_ahb_slave_decoder.sv
// Directed-vector bench for ahb_slave_decoder; HREADY is looped back from the mux output.
module tb_ahb_slave_decoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr;
  logic [1:0]  trans;
  logic        ready_in;
  logic [3:0]  sel;
  logic [127:0] rdata_in;
  logic [3:0]  rdyout;
  logic [3:0]  resp_in;
  logic [31:0] rdata;
  logic        ready;
  logic        resp;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign ready_in = ready;
  assign rdata_in = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  ahb_slave_decoder dut (
    .ahb_clk_in        (clk),
    .ahb_rstn_in       (rstn),
    .ahb_addr_in       (addr),
    .ahb_trans_in      (trans),
    .ahb_ready_in      (ready_in),
    .slave_sel_out     (sel),
    .slave_rdata_in    (rdata_in),
    .slave_readyout_in (rdyout),
    .slave_resp_in     (resp_in),
    .ahb_rdata_out     (rdata),
    .ahb_ready_out     (ready),
    .ahb_resp_out      (resp),
    .err_cnt_out       (err_cnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; addr = 32'h0; trans = 2'd0; rdyout = 4'hF; resp_in = 4'h0;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || resp !== 1'b0 || err_cnt !== 8'd0 || sel !== 4'h0 || rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold: ready=%b resp=%b cnt=%h sel=%h rdata=%h, want 1 0 00 0 0",
               ready, resp, err_cnt, sel, rdata);
    end
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || resp !== 1'b0 || err_cnt !== 8'd0 || sel !== 4'h0) begin
      n_err++;
      $display("FAIL reset_idle: ready=%b resp=%b cnt=%h sel=%h, want 1 0 00 0", ready, resp, err_cnt, sel);
    end
    next_cycle();
  endtask

  task automatic test_mapped_reads();
    logic [31:0] addrs [4] = '{32'h20300000, 32'h20300400, 32'h20300800, 32'h20300C00};
    logic [3:0]  sels  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int i = 0; i < 4; i++) begin
      addr = addrs[i]; trans = 2'd2;
      @(negedge clk);
      n_vec++;
      if (sel !== sels[i]) begin
        n_err++;
        $display("FAIL mapped_sel[%0d]: got %h want %h", i, sel, sels[i]);
      end
      if (i > 0) begin
        n_vec++;
        if (rdata !== exp_d[i-1] || ready !== 1'b1 || resp !== 1'b0) begin
          n_err++;
          $display("FAIL mapped_rdata[%0d]: got %h/%b/%b want %h/1/0", i-1, rdata, ready, resp, exp_d[i-1]);
        end
      end
      next_cycle();
    end
    addr = 32'h0; trans = 2'd0;
    @(negedge clk);
    n_vec++;
    if (rdata !== 32'hA3 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL mapped_rdata[3]: got %h/%b want 000000a3/1", rdata, ready);
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    if (rdata !== 32'h0 || ready !== 1'b1 || resp !== 1'b0) begin
      n_err++;
      $display("FAIL mapped_to_default: got %h/%b/%b want 0/1/0", rdata, ready, resp);
    end
  endtask

  task automatic test_wait_state();
    next_cycle();
    addr = 32'h20300400; trans = 2'd2;
    @(negedge clk);
    n_vec++;
    if (sel !== 4'h2) begin
      n_err++;
      $display("FAIL wait_sel1: got %h want 2", sel);
    end
    next_cycle();
    addr = 32'h20300800; trans = 2'd2; rdyout[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b0 || rdata !== 32'hA1 || sel !== 4'h4) begin
        n_err++;
        $display("FAIL wait_hold[%0d]: ready=%b rdata=%h sel=%h want 0 a1 4", c, ready, rdata, sel);
      end
      next_cycle();
    end
    rdyout[1] = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || rdata !== 32'hA1) begin
      n_err++;
      $display("FAIL wait_release: ready=%b rdata=%h want 1 a1", ready, rdata);
    end
    next_cycle();
    addr = 32'h0; trans = 2'd0;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || rdata !== 32'hA2) begin
      n_err++;
      $display("FAIL wait_owner2: ready=%b rdata=%h want 1 a2", ready, rdata);
    end
    next_cycle();
  endtask

  task automatic test_unmapped();
    logic [1:0] exp_rr [4] = '{2'b01, 2'b11, 2'b01, 2'b11};
    addr = 32'h20301000; trans = 2'd2;
    @(negedge clk);
    n_vec++;
    if (sel !== 4'h0 || ready !== 1'b1 || resp !== 1'b0) begin
      n_err++;
      $display("FAIL unmapped_addr: sel=%h ready=%b resp=%b want 0 1 0", sel, ready, resp);
    end
    next_cycle();
    addr = 32'h40000000;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) trans = 2'd0;
      @(negedge clk);
      n_vec++;
      if ({ready, resp} !== exp_rr[c] || rdata !== 32'h0) begin
        n_err++;
        $display("FAIL unmapped_seq[%0d]: ready/resp=%b%b rdata=%h want %b 0", c, ready, resp, rdata, exp_rr[c]);
      end
      next_cycle();
    end
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || resp !== 1'b0 || err_cnt !== 8'd2 || rdata !== 32'h0) begin
      n_err++;
      $display("FAIL unmapped_after: ready=%b resp=%b cnt=%h rdata=%h want 1 0 02 0", ready, resp, err_cnt, rdata);
    end
  endtask

  task automatic test_idle_unmapped();
    next_cycle();
    addr = 32'h40000000; trans = 2'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b1 || resp !== 1'b0 || err_cnt !== 8'd2) begin
        n_err++;
        $display("FAIL idle_unmapped[%0d]: ready=%b resp=%b cnt=%h want 1 0 02", c, ready, resp, err_cnt);
      end
      next_cycle();
    end
  endtask

  task automatic test_saturation_reset();
    bit found = 1'b0;
    addr = 32'h40000000; trans = 2'd2;
    repeat (520) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (err_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL saturate: cnt=%h want ff", err_cnt);
    end
    for (int c = 0; c < 4 && !found; c++) begin
      if (ready === 1'b0 && resp === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL err1_wait: no ERR1 cycle within bound, ready=%b resp=%b", ready, resp);
    end
    #1 rstn = 1'b0;
    #1;
    n_vec++;
    if (ready !== 1'b1 || resp !== 1'b0 || err_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid_err1: ready=%b resp=%b cnt=%h want 1 0 00", ready, resp, err_cnt);
    end
    trans = 2'd0;
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || resp !== 1'b0 || err_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL post_reset: ready=%b resp=%b cnt=%h want 1 0 00", ready, resp, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_mapped_reads();
    test_wait_state();
    test_unmapped();
    test_idle_unmapped();
    test_saturation_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
